// File: rtl/fractal_sync_pkg.sv
// Shared types and constants for the fractal sync request path.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fsync_req_state_e;

  localparam int unsigned FSYNC_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/fractal_sync_req_ctrl_ch.sv
// One request channel: accept a barrier request, pulse sync, wait for wake or timeout, respond.
module fractal_sync_req_ctrl_ch
  import fractal_sync_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = FSYNC_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  output logic req_ready_o,
  output logic rsp_valid_o,
  input  logic rsp_ready_i,
  output logic rsp_error_o,
  output logic sync_o,
  input  logic wake_i,
  input  logic node_error_i,
  output logic stale_wake_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  fsync_req_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             stale_q;
  logic             timeout;

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = ISSUE;
      ISSUE:   state_d = wake_i ? RESP : WAIT;
      WAIT:    if (wake_i || timeout) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ISSUE: begin
          if (wake_i) err_q <= node_error_i;
          else        cnt_q <= '0;
        end
        WAIT: begin
          // Wake takes priority over a coincident timeout.
          if (wake_i)       err_q <= node_error_i;
          else if (timeout) err_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
      if (wake_i && (state_q == IDLE || state_q == RESP)) stale_q <= 1'b1;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign sync_o       = (state_q == ISSUE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_error_o  = (state_q == RESP) && err_q;
  assign stale_wake_o = stale_q;

endmodule

// File: rtl/fractal_sync_req_ctrl.sv
// Upstream request controller: N_PORTS independent barrier channels toward the neighbor node.
module fractal_sync_req_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned TIMEOUT_CYCLES = FSYNC_TIMEOUT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_PORTS-1:0] req_valid_i,
  output logic [N_PORTS-1:0] req_ready_o,
  output logic [N_PORTS-1:0] rsp_valid_o,
  input  logic [N_PORTS-1:0] rsp_ready_i,
  output logic [N_PORTS-1:0] rsp_error_o,
  output logic [N_PORTS-1:0] sync_o,
  input  logic [N_PORTS-1:0] wake_i,
  input  logic [N_PORTS-1:0] node_error_i,
  output logic [N_PORTS-1:0] stale_wake_o
);

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ch
    fractal_sync_req_ctrl_ch #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i[gi]),
      .req_ready_o  (req_ready_o[gi]),
      .rsp_valid_o  (rsp_valid_o[gi]),
      .rsp_ready_i  (rsp_ready_i[gi]),
      .rsp_error_o  (rsp_error_o[gi]),
      .sync_o       (sync_o[gi]),
      .wake_i       (wake_i[gi]),
      .node_error_i (node_error_i[gi]),
      .stale_wake_o (stale_wake_o[gi])
    );
  end

endmodule

// File: tb/tb_fractal_sync_req_ctrl.sv
// Directed bench: dut_a uses the default timeout, dut_b a 4-cycle timeout; both share stimulus.
module tb_fractal_sync_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0, rsp_ready = '0, wake = '0, node_error = '0;
  logic [1:0] a_req_ready, a_rsp_valid, a_rsp_error, a_sync, a_stale;
  logic [1:0] b_req_ready, b_rsp_valid, b_rsp_error, b_sync, b_stale;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  fractal_sync_req_ctrl #(.N_PORTS(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_error_o(a_rsp_error),
    .sync_o(a_sync), .wake_i(wake), .node_error_i(node_error), .stale_wake_o(a_stale)
  );

  fractal_sync_req_ctrl #(.N_PORTS(2), .TIMEOUT_CYCLES(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_error_o(b_rsp_error),
    .sync_o(b_sync), .wake_i(wake), .node_error_i(node_error), .stale_wake_o(b_stale)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; wake = '0; node_error = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req_ready", 32'(a_req_ready), 32'h3);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("rst_rsp_error", 32'(a_rsp_error), 32'h0);
    chk("rst_sync", 32'(a_sync), 32'h0);
    chk("rst_stale", 32'(a_stale), 32'h0);

    // Both channels, sequential node (wake one cycle after sync)
    req_valid = 2'b11;                                 // cycle 0
    tick(); req_valid = 2'b00;                         // cycle 1
    chk("t1_sync_c1", 32'(a_sync), 32'h3);
    chk("t1_ready_c1", 32'(a_req_ready), 32'h0);
    tick(); wake = 2'b11;                              // cycle 2
    chk("t1_sync_c2", 32'(a_sync), 32'h0);
    chk("t1_valid_c2", 32'(a_rsp_valid), 32'h0);
    tick(); wake = 2'b00;                              // cycle 3
    chk("t1_valid_c3", 32'(a_rsp_valid), 32'h3);
    chk("t1_error_c3", 32'(a_rsp_error), 32'h0);
    rsp_ready = 2'b11;
    tick(); rsp_ready = 2'b00;                         // cycle 4
    chk("t1_valid_c4", 32'(a_rsp_valid), 32'h0);
    chk("t1_ready_c4", 32'(a_req_ready), 32'h3);
    chk("t1_stale", 32'(a_stale), 32'h0);

    // Staggered requests, combinational node
    do_reset();
    req_valid = 2'b01;                                 // cycle 0
    tick(); req_valid = 2'b00;                         // cycle 1
    chk("t2_sync_c1", 32'(a_sync), 32'h1);
    for (int c = 2; c <= 10; c++) tick();              // cycle 10
    chk("t2_valid_c10", 32'(a_rsp_valid), 32'h0);
    chk("t2_ready_c10", 32'(a_req_ready), 32'h2);
    req_valid = 2'b10;
    tick(); req_valid = 2'b00;                         // cycle 11
    chk("t2_sync_c11", 32'(a_sync), 32'h2);
    wake = 2'b11;
    tick(); wake = 2'b00;                              // cycle 12
    chk("t2_valid_c12", 32'(a_rsp_valid), 32'h3);
    chk("t2_error_c12", 32'(a_rsp_error), 32'h0);
    chk("t2_stale", 32'(a_stale), 32'h0);
    rsp_ready = 2'b11;
    tick(); rsp_ready = 2'b00;

    // Timeout on dut_b, then backpressure and a late stale wake
    do_reset();
    req_valid = 2'b01;                                 // cycle 0
    tick(); req_valid = 2'b00;                         // cycle 1
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("t3_wait_valid_c%0d", c), 32'(b_rsp_valid), 32'h0);
    end
    tick();                                            // cycle 6
    chk("t3_valid_c6", 32'(b_rsp_valid), 32'h1);
    chk("t3_error_c6", 32'(b_rsp_error), 32'h1);
    chk("t3_ready_c6", 32'(b_req_ready), 32'h2);
    for (int c = 0; c < 5; c++) begin
      wake = (c == 2) ? 2'b01 : 2'b00;
      tick();
      chk($sformatf("t3_hold_valid_%0d", c), 32'(b_rsp_valid), 32'h1);
      chk($sformatf("t3_hold_error_%0d", c), 32'(b_rsp_error), 32'h1);
      chk($sformatf("t3_hold_ready_%0d", c), 32'(b_req_ready), 32'h2);
      chk($sformatf("t3_stale_%0d", c), 32'(b_stale), (c >= 2) ? 32'h1 : 32'h0);
    end
    wake = 2'b00; rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    chk("t3_valid_done", 32'(b_rsp_valid), 32'h0);
    chk("t3_error_done", 32'(b_rsp_error), 32'h0);
    chk("t3_stale_sticky", 32'(b_stale), 32'h1);

    // Wake on the last timeout cycle wins on dut_b
    do_reset();
    req_valid = 2'b01;
    tick(); req_valid = 2'b00;                         // cycle 1
    for (int c = 2; c <= 5; c++) tick();               // cycle 5, counter==3
    wake = 2'b01;
    tick(); wake = 2'b00;                              // cycle 6
    chk("t4_valid", 32'(b_rsp_valid), 32'h1);
    chk("t4_error", 32'(b_rsp_error), 32'h0);
    chk("t4_stale", 32'(b_stale), 32'h0);
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;

    // Wake during ISSUE carries the node error through
    do_reset();
    req_valid = 2'b10;
    tick(); req_valid = 2'b00;                         // cycle 1
    wake = 2'b10; node_error = 2'b10;
    tick(); wake = 2'b00; node_error = 2'b00;          // cycle 2
    chk("t5_valid", 32'(a_rsp_valid), 32'h2);
    chk("t5_error", 32'(a_rsp_error), 32'h2);
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;
    chk("t5_ready", 32'(a_req_ready), 32'h3);

    // Asynchronous reset in WAIT, then a clean barrier
    do_reset();
    req_valid = 2'b11;
    tick(); req_valid = 2'b00;                         // cycle 1
    tick();                                            // cycle 2, WAIT
    chk("t6_ready_wait", 32'(a_req_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_valid", 32'(a_rsp_valid), 32'h0);
    chk("t6_arst_sync", 32'(a_sync), 32'h0);
    chk("t6_arst_ready", 32'(a_req_ready), 32'h3);
    tick();
    #2 rst = 1'b0;
    tick();
    req_valid = 2'b11;
    tick(); req_valid = 2'b00;
    chk("t6_sync", 32'(a_sync), 32'h3);
    tick(); wake = 2'b11;
    tick(); wake = 2'b00;
    chk("t6_valid", 32'(a_rsp_valid), 32'h3);
    chk("t6_error", 32'(a_rsp_error), 32'h0);
    rsp_ready = 2'b11;
    tick(); rsp_ready = 2'b00;
    chk("t6_ready_end", 32'(a_req_ready), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
